instr_encoder: RTL



---
 rtl/instr_encoder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// RV32I field-bundle encoder: packs one instruction per handshake and writes it
// sequentially into instruction memory. Optional immediate range checking: ENC_IMM_CHECK_EN.
//
// state   | meaning
// S_IDLE  | ready for a bundle (unless full or clr)
// S_WRITE | mem_we high, holding addr/wdata until mem_ack
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        cls,
    input  logic [2:0]        funct3,
    input  logic              alt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              clr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH   = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [0:0]      S_IDLE  = 1'b0;
    localparam logic [0:0]      S_WRITE = 1'b1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    logic [6:0]  f7_alt;
    logic [31:0] enc_raw;
    logic [31:0] enc_word;
    logic        viol;

    always_comb begin
        enc_raw = NOP;
        f7_alt  = alt ? 7'b0100000 : 7'b0000000;
        case (cls)
            3'd0: enc_raw = {((funct3 == 3'b000) || (funct3 == 3'b101)) ? f7_alt : 7'b0000000,
                             rs2, rs1, funct3, rd, OP_R};
            3'd1: begin
                if (funct3 == 3'b001)
                    enc_raw = {7'b0000000, imm[4:0], rs1, funct3, rd, OP_IMM};
                else if (funct3 == 3'b101)
                    enc_raw = {f7_alt, imm[4:0], rs1, funct3, rd, OP_IMM};
                else
                    enc_raw = {imm[11:0], rs1, funct3, rd, OP_IMM};
            end
            3'd2: enc_raw = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            3'd3: enc_raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            3'd4: enc_raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            3'd5: enc_raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            3'd6: enc_raw = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            default: enc_raw = NOP;
        endcase
    end

`ifdef ENC_IMM_CHECK_EN
    logic signed [31:0] imm_s;
    assign imm_s = imm;

    always_comb begin
        viol = 1'b0;
        case (cls)
            3'd1: begin
                if ((funct3 == 3'b001) || (funct3 == 3'b101))
                    viol = (imm_s < 0) || (imm_s > 31);
                else
                    viol = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            3'd2, 3'd3, 3'd6: viol = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            3'd4: viol = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
            3'd5: viol = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
            3'd7: viol = 1'b1;
            default: viol = 1'b0;
        endcase
    end
`else
    // Without range checking the upper immediate bits are simply truncated.
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:21];
    assign viol = 1'b0;
`endif

    assign enc_word = viol ? NOP : enc_raw;

    assign full      = (count_q == DEPTH);
    assign in_ready  = (state_q == S_IDLE) && !full && !clr;
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = ptr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        if (state_q == S_IDLE) begin
            if (clr) begin
                ptr_d   = '0;
                count_d = '0;
                err_d   = 1'b0;
            end else if (in_valid && in_ready) begin
                wdata_d = enc_word;
                err_d   = err_q | viol;
                state_d = S_WRITE;
            end
        end else if (mem_ack) begin
            // Pointer wraps to 0 on the final write; count parks at DEPTH.
            ptr_d   = ptr_q + ADDR_W'(1);
            count_d = full ? count_q : count_q + (ADDR_W+1)'(1);
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

endmodule
